// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
//   Time-multiplexed scan controller for a NUM_DIGITS common-select
//   seven-segment display sharing one BCD-to-segment decoder. Each digit
//   slot is REFRESH_DIV clocks: BLANK_CYCLES dark guard cycles followed by
//   the SHOW window. Digit data is double-buffered (shadow -> active) and
//   committed only at frame end, or immediately while idle.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   enable     1 = scanning, 0 = display dark (IDLE)
//   load       1-cycle strobe, capture digits_in into the shadow buffer
//   digits_in  packed BCD, digit k at [4k+3:4k]
//   lz_blank   1 = suppress leading zeros
//   seg_in     shared decoder output (gfedcba, active-high)
//   num_out    registered BCD value feeding the shared decoder
//   seg_out    gated segment drive, active-high
//   an_out     one-hot digit select, active-high
//   pending    shadow holds data not yet committed to active
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    lz_blank,
    input  logic [6:0]              seg_in,
    output logic [3:0]              num_out,
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    pending
);

    localparam int IDXW        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNTW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int SHOW_CYCLES = REFRESH_DIV - BLANK_CYCLES;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        SHOW
    } state_t;

    state_t                  state, state_nx;
    logic [IDXW-1:0]         idx, idx_nx;
    logic [CNTW-1:0]         cnt, cnt_nx;
    logic [4*NUM_DIGITS-1:0] active, active_nx;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic                    frame_end;
    logic                    commit;
    logic                    enter_blank;
    logic [3:0]              num_nx;
    logic                    upper_zero;
    logic                    suppress;

    function automatic logic [3:0] digit_at(input logic [4*NUM_DIGITS-1:0] v,
                                            input logic [IDXW-1:0]         i);
        digit_at = '0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (i == IDXW'(k)) digit_at = v[4*k +: 4];
        end
    endfunction

    // Commit path: a load coinciding with the commit bypasses the shadow so
    // the freshest data lands in active without an extra frame of latency.
    always_comb begin
        frame_end = (state == SHOW) && (idx == IDXW'(NUM_DIGITS-1)) &&
                    (cnt == CNTW'(SHOW_CYCLES-1));
        commit    = frame_end || ((state == IDLE) && pending);
        active_nx = active;
        if (commit) active_nx = load ? digits_in : shadow;
    end

    always_comb begin
        state_nx    = state;
        idx_nx      = idx;
        cnt_nx      = cnt;
        enter_blank = 1'b0;
        if (!enable) begin
            state_nx = IDLE;
            idx_nx   = '0;
            cnt_nx   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_nx    = BLANK;
                    idx_nx      = '0;
                    cnt_nx      = '0;
                    enter_blank = 1'b1;
                end
                BLANK: begin
                    if (cnt == CNTW'(BLANK_CYCLES-1)) begin
                        state_nx = SHOW;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                SHOW: begin
                    if (cnt == CNTW'(SHOW_CYCLES-1)) begin
                        state_nx    = BLANK;
                        cnt_nx      = '0;
                        idx_nx      = (idx == IDXW'(NUM_DIGITS-1)) ? '0 : idx + 1'b1;
                        enter_blank = 1'b1;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    idx_nx   = '0;
                    cnt_nx   = '0;
                end
            endcase
        end
        // Uses the post-commit buffer so the first slot of a new frame
        // already decodes the newly committed digits.
        num_nx = digit_at(active_nx, idx_nx);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            cnt     <= '0;
            active  <= '0;
            shadow  <= '0;
            pending <= 1'b0;
            num_out <= '0;
        end else begin
            state  <= state_nx;
            idx    <= idx_nx;
            cnt    <= cnt_nx;
            active <= active_nx;
            if (load) shadow <= digits_in;
            if (commit)    pending <= 1'b0;
            else if (load) pending <= 1'b1;
            if (enter_blank) num_out <= num_nx;
        end
    end

    // A digit is dark when its code is not BCD, or when it is a leading zero:
    // it and every more-significant digit are zero (digit 0 always shows).
    always_comb begin
        upper_zero = ((active >> {idx, 2'b00}) == '0);
        suppress   = (num_out > 4'd9) || (lz_blank && (idx != '0) && upper_zero);
        an_out     = '0;
        seg_out    = '0;
        if (state == SHOW) begin
            for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
                an_out[k] = (idx == IDXW'(k));
            end
            if (!suppress) seg_out = seg_in;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;

    localparam int ND = 4;
    localparam int RD = 8;
    localparam int BC = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        load;
    logic [15:0] digits_in;
    logic        lz_blank;
    logic [6:0]  seg_in;
    logic [3:0]  num_out;
    logic [6:0]  seg_out;
    logic [3:0]  an_out;
    logic        pending;

    logic        use_dec;
    logic [6:0]  rnd_seg;

    int nchk = 0;
    int nerr = 0;

    seg_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .load     (load),
        .digits_in(digits_in),
        .lz_blank (lz_blank),
        .seg_in   (seg_in),
        .num_out  (num_out),
        .seg_out  (seg_out),
        .an_out   (an_out),
        .pending  (pending)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] dec(input logic [3:0] v);
        case (v)
            4'd0: dec = 7'h3f;
            4'd1: dec = 7'h06;
            4'd2: dec = 7'h5b;
            4'd3: dec = 7'h4f;
            4'd4: dec = 7'h66;
            4'd5: dec = 7'h6d;
            4'd6: dec = 7'h7d;
            4'd7: dec = 7'h07;
            4'd8: dec = 7'h7f;
            4'd9: dec = 7'h6f;
            default: dec = 7'h49;
        endcase
    endfunction

    // Shared decoder stand-in (or arbitrary pattern for random phase).
    assign seg_in = use_dec ? dec(num_out) : rnd_seg;

    function automatic logic [3:0] nib(input logic [15:0] v, input int unsigned k);
        logic [15:0] s;
        s = v >> (4*k);
        return s[3:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: time since scanning started, slot = t/RD,
    // digit = slot mod ND, dark while (t mod RD) < BC.
    logic        m_scan;
    int unsigned m_t;
    logic [15:0] m_active;
    logic [15:0] m_shadow;
    logic        m_pending;
    logic [3:0]  m_num;

    task automatic model_reset();
        m_scan = 1'b0; m_t = 0; m_active = '0; m_shadow = '0;
        m_pending = 1'b0; m_num = '0;
    endtask

    task automatic model_check();
        int unsigned slot;
        logic        show;
        logic        sup;
        logic [3:0]  e_an;
        logic [6:0]  e_seg;
        logic [15:0] upper;
        slot  = (m_t / RD) % ND;
        show  = m_scan && ((m_t % RD) >= BC);
        upper = m_active >> (4*slot);
        sup   = (m_num > 4'd9) || (lz_blank && slot != 0 && upper == 16'h0);
        e_an  = show ? 4'(1 << slot) : 4'h0;
        e_seg = (show && !sup) ? (use_dec ? dec(m_num) : rnd_seg) : 7'h0;
        chk("an_out",  32'(an_out),  32'(e_an));
        chk("seg_out", 32'(seg_out), 32'(e_seg));
        chk("num_out", 32'(num_out), 32'(m_num));
        chk("pending", 32'(pending), 32'(m_pending));
    endtask

    task automatic model_update(input logic en, input logic ld, input logic [15:0] din);
        logic commit;
        commit = (m_scan && (m_t % (RD*ND)) == RD*ND-1) || (!m_scan && m_pending);
        if (commit) begin
            m_active  = ld ? din : m_shadow;
            m_pending = 1'b0;
        end else if (ld) begin
            m_pending = 1'b1;
        end
        if (ld) m_shadow = din;
        if (!en) begin
            m_scan = 1'b0;
        end else if (!m_scan) begin
            m_scan = 1'b1;
            m_t    = 0;
            m_num  = nib(m_active, 0);
        end else begin
            m_t++;
            if (m_t % RD == 0) m_num = nib(m_active, (m_t / RD) % ND);
        end
    endtask

    // One clock: drive inputs after the falling edge, check, advance model.
    task automatic step(input logic en, input logic ld, input logic [15:0] din, input logic lz);
        @(negedge clk);
        enable = en; load = ld; digits_in = din; lz_blank = lz;
        if (!use_dec) rnd_seg = 7'($urandom);
        #1;
        model_check();
        model_update(en, ld, din);
    endtask

    typedef struct {
        logic [15:0]     digits;
        logic            lz;
        logic [3:0][6:0] exp_seg;   // index = digit number
    } vec_t;

    vec_t tbl [6];

    initial begin
        tbl[0] = '{16'h4321, 1'b0, {7'h66, 7'h4f, 7'h5b, 7'h06}};
        tbl[1] = '{16'h0070, 1'b1, {7'h00, 7'h00, 7'h07, 7'h3f}};
        tbl[2] = '{16'h0070, 1'b0, {7'h3f, 7'h3f, 7'h07, 7'h3f}};
        tbl[3] = '{16'h0000, 1'b1, {7'h00, 7'h00, 7'h00, 7'h3f}};
        tbl[4] = '{16'h0A05, 1'b0, {7'h3f, 7'h00, 7'h3f, 7'h6d}};
        tbl[5] = '{16'h9F08, 1'b1, {7'h6f, 7'h00, 7'h3f, 7'h7f}};

        rst_n = 1'b0; enable = 1'b0; load = 1'b0; digits_in = '0;
        lz_blank = 1'b0; use_dec = 1'b1; rnd_seg = '0;
        model_reset();
        #12;
        chk("rst_an",      32'(an_out),  32'h0);
        chk("rst_seg",     32'(seg_out), 32'h0);
        chk("rst_num",     32'(num_out), 32'h0);
        chk("rst_pending", 32'(pending), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: load while idle, start scanning, walk one full frame.
        for (int e = 0; e < 6; e++) begin
            step(1'b0, 1'b1, tbl[e].digits, tbl[e].lz);
            step(1'b0, 1'b0, tbl[e].digits, tbl[e].lz);
            step(1'b1, 1'b0, tbl[e].digits, tbl[e].lz);
            for (int c = 0; c < RD*ND; c++) begin
                int k;
                step(1'b1, 1'b0, tbl[e].digits, tbl[e].lz);
                k = c / RD;
                if (c % RD < BC) begin
                    chk("tbl_an_blank",  32'(an_out),  32'h0);
                    chk("tbl_seg_blank", 32'(seg_out), 32'h0);
                end else begin
                    chk("tbl_an_show",  32'(an_out),  32'(1 << k));
                    chk("tbl_seg_show", 32'(seg_out), 32'(tbl[e].exp_seg[k]));
                end
                chk("tbl_num", 32'(num_out), 32'(nib(tbl[e].digits, k)));
            end
        end

        // Frame-boundary update: 0x1234 active, load 0x5678 mid digit 1.
        step(1'b0, 1'b1, 16'h1234, 1'b0);
        step(1'b0, 1'b0, 16'h1234, 1'b0);
        step(1'b1, 1'b0, 16'h1234, 1'b0);
        for (int c = 0; c < 40; c++) begin
            step(1'b1, c == 12, 16'h5678, 1'b0);
            if (c == 13 || c == 31) chk("fb_pending_hi", 32'(pending), 32'h1);
            if (c == 20) chk("fb_old_digit2", 32'(num_out), 32'h2);
            if (c == 28) chk("fb_old_digit3", 32'(num_out), 32'h1);
            if (c == 32) begin
                chk("fb_pending_lo",  32'(pending), 32'h0);
                chk("fb_new_digit0",  32'(num_out), 32'h8);
            end
            if (c == 36) chk("fb_new_seg0", 32'(seg_out), 32'h7f);
        end

        // Load exactly on the frame-end cycle while 0x1111 sits in shadow.
        step(1'b0, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b0, 16'h0, 1'b0);
        for (int c = 0; c < 42; c++) begin
            step(1'b1, c == 5 || c == 31, (c == 5) ? 16'h1111 : 16'h9999, 1'b0);
            if (c == 31) chk("lc_pending_pre",  32'(pending), 32'h1);
            if (c == 32) chk("lc_pending_post", 32'(pending), 32'h0);
            if (c == 32) chk("lc_digit0",       32'(num_out), 32'h9);
            if (c == 40) chk("lc_digit1",       32'(num_out), 32'h9);
        end

        // Enable dropped mid-frame, then restarted.
        for (int c = 0; c < 20; c++) begin
            step(c != 10, 1'b0, 16'h0, 1'b0);
            if (c == 11 || c == 12 || c == 13) chk("en_dark", 32'(an_out), 32'h0);
            if (c == 14) chk("en_restart_d0", 32'(an_out), 32'h1);
        end

        // Asynchronous reset in the middle of a SHOW window with pending set.
        step(1'b0, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b0, 16'h0, 1'b0);
        for (int c = 0; c < 5; c++) step(1'b1, c == 3, 16'h2468, 1'b0);
        chk("pre_rst_pending", 32'(pending), 32'h1);
        chk("pre_rst_an",      32'(an_out),  32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_an",      32'(an_out),  32'h0);
        chk("async_rst_seg",     32'(seg_out), 32'h0);
        chk("async_rst_pending", 32'(pending), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) step(1'b0, 1'b0, 16'h0, 1'b0);

        // Randomized traffic against the model.
        use_dec = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            logic [15:0] d;
            logic        lz;
            for (int k = 0; k < 4; k++)
                d[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            lz = ((c / 256) % 2) == 1;
            step($urandom_range(0, 99) != 0, $urandom_range(0, 15) == 0, d, lz);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
